// File: rtl/alu_seq_if.sv
// Switch/button inputs and registered result/flag outputs of the ALU sequencer.
interface alu_seq_if #(
    parameter int unsigned BUS_WIDTH = 16
);
    logic [BUS_WIDTH-1:0] i_switches;
    logic                 i_button;
    logic [BUS_WIDTH-1:0] o_result;
    logic                 o_zero;
    logic                 o_carry;
    logic                 o_overflow;
    logic                 o_valid;
    logic [1:0]           o_state;

    modport master (
        output i_switches, i_button,
        input  o_result, o_zero, o_carry, o_overflow, o_valid, o_state
    );

    modport slave (
        input  i_switches, i_button,
        output o_result, o_zero, o_carry, o_overflow, o_valid, o_state
    );
endinterface

// File: rtl/alu_sequencer.sv
// Button-stepped operand/opcode capture feeding a registered ALU.
// Define ALU_SEQ_DEBOUNCE_EN to enable the stable-level button filter.
module alu_sequencer #(
    parameter int unsigned BUS_WIDTH       = 16,
    parameter int unsigned OP_WIDTH        = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {StA = 2'b00, StB = 2'b01, StOp = 2'b10, StRes = 2'b11} state_e;

    localparam logic [OP_WIDTH-1:0] OpAdd = OP_WIDTH'(6'b100000);
    localparam logic [OP_WIDTH-1:0] OpSub = OP_WIDTH'(6'b100010);
    localparam logic [OP_WIDTH-1:0] OpAnd = OP_WIDTH'(6'b100100);
    localparam logic [OP_WIDTH-1:0] OpOr  = OP_WIDTH'(6'b100101);
    localparam logic [OP_WIDTH-1:0] OpXor = OP_WIDTH'(6'b100110);
    localparam logic [OP_WIDTH-1:0] OpNor = OP_WIDTH'(6'b100111);
    localparam logic [OP_WIDTH-1:0] OpSrl = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OpSra = OP_WIDTH'(6'b000011);

    if (BUS_WIDTH < 4 || DEBOUNCE_CYCLES < 2 || OP_WIDTH > BUS_WIDTH) begin : g_param_check
        $error("alu_sequencer: illegal parameter combination");
    end

    logic [1:0] sync_q;
    logic       level;
    logic       hist_q;
    logic       advance;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    logic [CntW-1:0] cnt_q;
    logic            level_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end
    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], bus.i_button};
            hist_q <= level;
        end
    end
    assign advance = level & ~hist_q;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_WIDTH-1:0]  op_q, op_d;
    logic                 zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;

    logic [BUS_WIDTH:0]   sum, diff;
    logic [BUS_WIDTH-1:0] alu_res;
    logic                 alu_c, alu_v, sh_big, msb_a, msb_b;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        msb_a   = a_q[BUS_WIDTH-1];
        msb_b   = b_q[BUS_WIDTH-1];
        sh_big  = (b_q >= BUS_WIDTH'(BUS_WIDTH));
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_res = sum[BUS_WIDTH-1:0];
                alu_c   = sum[BUS_WIDTH];
                alu_v   = (msb_a == msb_b) && (sum[BUS_WIDTH-1] != msb_a);
            end
            OpSub: begin
                alu_res = diff[BUS_WIDTH-1:0];
                alu_c   = diff[BUS_WIDTH];
                alu_v   = (msb_a != msb_b) && (diff[BUS_WIDTH-1] != msb_a);
            end
            OpAnd: alu_res = a_q & b_q;
            OpOr:  alu_res = a_q | b_q;
            OpXor: alu_res = a_q ^ b_q;
            OpNor: alu_res = ~(a_q | b_q);
            OpSrl: alu_res = sh_big ? '0 : (a_q >> b_q);
            OpSra: alu_res = sh_big ? {BUS_WIDTH{msb_a}} : BUS_WIDTH'($signed(a_q) >>> b_q);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        unique case (state_q)
            StA: if (advance) begin
                a_d     = bus.i_switches;
                state_d = StB;
            end
            StB: if (advance) begin
                b_d     = bus.i_switches;
                state_d = StOp;
            end
            StOp: if (advance) begin
                op_d    = bus.i_switches[OP_WIDTH-1:0];
                state_d = StRes;
            end
            StRes: begin
                // Result loads once, on the first edge spent in StRes.
                if (!valid_q) begin
                    res_d   = alu_res;
                    zero_d  = (alu_res == '0);
                    carry_d = alu_c;
                    ovf_d   = alu_v;
                    valid_d = 1'b1;
                end
                if (advance) begin
                    valid_d = 1'b0;
                    state_d = StA;
                end
            end
            default: state_d = StA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_result   = res_q;
    assign bus.o_zero     = zero_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_state    = state_q;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, the operand and result width (minimum 4).
REQ-002 SHALL have parameter OP_WIDTH, default 6, the opcode width taken from i_switches[OP_WIDTH-1:0].
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000, the stable-level cycle count for the button filter (minimum 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port i_switches, input, BUS_WIDTH, the operand/opcode source.
REQ-007 SHALL have port i_button, input, 1, the asynchronous raw advance button.
REQ-008 SHALL have port o_result, output, BUS_WIDTH, the registered ALU result.
REQ-009 SHALL have ports o_zero, o_carry, o_overflow, output, 1 each, the registered flags.
REQ-010 SHALL have port o_valid, output, 1, high while o_result holds the result of the current operand set.
REQ-011 SHALL have port o_state, output, 2, the FSM state code.

Function
REQ-012 SHALL pass i_button through a 2-flop synchroniser, then the filter (REQ-033), then a rising-edge detector producing a one-cycle advance pulse.
REQ-013 SHALL implement FSM states S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_RES=2'b11, driven on o_state.
REQ-014 On advance pulse in S_A: capture i_switches into reg A, go to S_B.
REQ-015 On advance pulse in S_B: capture i_switches into reg B, go to S_OP.
REQ-016 On advance pulse in S_OP: capture i_switches[OP_WIDTH-1:0] into reg OP, go to S_RES.
REQ-017 On the first clock edge in S_RES, o_result and flags SHALL load from the ALU on A/B/OP and o_valid SHALL go to 1 (one cycle after OP capture).
REQ-018 On advance pulse in S_RES: go to S_A, clear o_valid; A, B, OP, o_result and flags SHALL hold.
REQ-019 Without an advance pulse the state and all capture registers SHALL hold.
REQ-020 Opcodes: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRL 6'b000010, SRA 6'b000011.
REQ-021 ADD: result A+B modulo 2^BUS_WIDTH; o_carry = carry-out bit BUS_WIDTH; o_overflow = signed two's-complement overflow.
REQ-022 SUB: result A-B modulo 2^BUS_WIDTH; o_carry = 1 iff A<B unsigned (borrow); o_overflow = signed overflow.
REQ-023 Logic ops and shifts: o_carry = 0, o_overflow = 0.
REQ-024 SRL/SRA: shift A right by unsigned B; B >= BUS_WIDTH gives 0 (SRL) or all copies of A's MSB (SRA).
REQ-025 Undefined opcode: result 0, o_carry 0, o_overflow 0.
REQ-026 o_zero SHALL be 1 iff the loaded result equals 0.
REQ-027 A button held continuously SHALL produce exactly one advance pulse; a new pulse requires release then press.

Reset
REQ-028 reset SHALL take priority over the advance pulse on the same edge.
REQ-029 On reset: state S_A; A, B, OP, o_result, o_carry, o_overflow, o_valid = 0; o_zero = 0.
REQ-030 On reset: synchroniser flops, filter counter, filtered level and edge-detector history = 0.
REQ-031 A button held through reset release SHALL generate one advance pulse once it passes the filter.
REQ-032 Reset asserted mid-sequence (any state) SHALL discard captured operands; no partial result is retained.

Configuration
REQ-033 Macro ALU_SEQ_DEBOUNCE_EN defined: filtered level updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-034 Macro ALU_SEQ_DEBOUNCE_EN undefined: filtered level = synchronised input; counter and DEBOUNCE_CYCLES unused; pulse 3 cycles after button rise.

Verification
REQ-035 BUS_WIDTH=16, load A=0x7FFF, B=0x0001, OP=ADD -> o_result 0x8000, o_overflow 1, o_carry 0, o_zero 0, o_valid 1 one cycle after OP capture.
REQ-036 A=0x0003, B=0x0005, OP=SUB -> o_result 0xFFFE, o_carry 1, o_overflow 0.
REQ-037 A=0x8000, B=0x0014, OP=SRA -> o_result 0xFFFF; OP=SRL same operands -> 0x0000, o_zero 1.
REQ-038 Macro defined, DEBOUNCE_CYCLES=8: 5-cycle glitch pulses -> no state change; 20-cycle press -> exactly one advance, o_state 00->01.
REQ-039 Reset asserted in S_OP with A, B loaded -> next cycle o_state 00, all outputs 0; next full sequence A=B=0x0000, OP=XOR -> o_zero 1.
REQ-040 OP=6'b111111 -> o_result 0, o_zero 1; further press in S_RES -> o_state 00, o_valid 0, o_result held.
